adc_ctrl_axil_regs: RTL and testbench

AXI4-Lite slave register file for the ADC controller, the responder end of the bus that the processor-side master uses. It holds control and config registers and emits a one-cycle conversion start pulse. It captures ADC samples into a read-only data register and reports ready and overrun status.

---
 rtl/adc_ctrl_axil_regs.sv | 228 ++++++++++++++++++++++
 tb/tb_adc_ctrl_axil_regs.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ctrl_axil_regs.sv
// AXI4-Lite register file for the ADC controller: control/config registers, sample capture and status.
// Optional build macro ADC_CTRL_IRQ_EN adds a registered irq_o output.
module adc_ctrl_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int ADC_DATA_WIDTH     = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [ADC_DATA_WIDTH-1:0]       adc_data_i,
    input  logic                            adc_data_valid_i,
    output logic                            adc_start_o,
    output logic                            adc_enable_o,
    output logic [15:0]                     adc_clkdiv_o
`ifdef ADC_CTRL_IRQ_EN
    ,
    output logic                            irq_o
`endif
);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t    w_state_reg;
    r_state_t    r_state_reg;
    logic        awready_reg, wready_reg, bvalid_reg;
    logic [1:0]  bresp_reg;
    logic        arready_reg, rvalid_reg;
    logic [1:0]  rresp_reg;
    logic [31:0] rdata_reg;
    logic        start_reg;
    logic        data_ready_reg, overrun_reg;
    logic [31:0] data_reg;

    logic [2:0]  waddr, raddr;
    logic        wr_fire, rd_fire, wr_mapped;
    logic [31:0] ctrl, clkdiv, scratch, thresh;
    logic [31:0] rd_mux;
    logic        rd_mapped;
    logic        rd_data_clr, ovr_clr;

    logic        unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign waddr     = S_AXI_AWADDR[4:2];
    assign raddr     = S_AXI_ARADDR[4:2];
    assign wr_fire   = awready_reg && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_fire   = arready_reg && S_AXI_ARVALID;
    assign wr_mapped = !(waddr[2] && waddr[1]);

    // Write channel: ready is raised only once both AW and W are presented.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_reg <= W_IDLE;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= 2'b00;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (awready_reg) begin
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b0;
                        if (wr_fire) begin
                            bvalid_reg  <= 1'b1;
                            bresp_reg   <= wr_mapped ? 2'b00 : 2'b10;
                            w_state_reg <= W_RESP;
                        end
                    end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        awready_reg <= 1'b1;
                        wready_reg  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_reg  <= 1'b0;
                        bresp_reg   <= 2'b00;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // Read data is captured on the address handshake and held until RREADY.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= 2'b00;
            rdata_reg   <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (arready_reg) begin
                        arready_reg <= 1'b0;
                        if (rd_fire) begin
                            rvalid_reg  <= 1'b1;
                            rdata_reg   <= rd_mux;
                            rresp_reg   <= rd_mapped ? 2'b00 : 2'b10;
                            r_state_reg <= R_DATA;
                        end
                    end else if (S_AXI_ARVALID) begin
                        arready_reg <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_reg  <= 1'b0;
                        r_state_reg <= R_IDLE;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // Four byte-lane writable registers: CTRL, CLKDIV, SCRATCH, THRESH.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rw
            logic [31:0] value_reg;
            always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
                if (!S_AXI_ARESETN) begin
                    value_reg <= '0;
                end else if (wr_fire && waddr == 3'(gi)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (S_AXI_WSTRB[b]) begin
                            value_reg[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    assign ctrl    = g_rw[0].value_reg;
    assign clkdiv  = g_rw[1].value_reg;
    assign scratch = g_rw[2].value_reg;
    assign thresh  = g_rw[3].value_reg;

    assign rd_data_clr = rd_fire && raddr == 3'd5;
    assign ovr_clr     = wr_fire && waddr == 3'd4 && S_AXI_WSTRB[0] && S_AXI_WDATA[1];

    // A sample arriving while DATA is being read refills it without flagging overrun.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            data_reg       <= '0;
            data_ready_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            start_reg      <= 1'b0;
        end else begin
            start_reg <= wr_fire && waddr == 3'd0 && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
            if (adc_data_valid_i) begin
                data_reg       <= 32'(adc_data_i);
                data_ready_reg <= 1'b1;
            end else if (rd_data_clr) begin
                data_ready_reg <= 1'b0;
            end
            if (adc_data_valid_i && data_ready_reg && !rd_data_clr) begin
                overrun_reg <= 1'b1;
            end else if (ovr_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux    = '0;
        rd_mapped = 1'b1;
        case (raddr)
            3'd0:    rd_mux = ctrl;
            3'd1:    rd_mux = clkdiv;
            3'd2:    rd_mux = scratch;
            3'd3:    rd_mux = thresh;
            3'd4:    rd_mux = {30'b0, overrun_reg, data_ready_reg};
            3'd5:    rd_mux = data_reg;
            default: rd_mapped = 1'b0;
        endcase
    end

`ifdef ADC_CTRL_IRQ_EN
    logic irq_reg;
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= data_ready_reg & ctrl[2];
        end
    end
    assign irq_o = irq_reg;
`endif

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = wready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RRESP   = rresp_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign adc_start_o   = start_reg;
    assign adc_enable_o  = ctrl[1];
    assign adc_clkdiv_o  = clkdiv[15:0];

endmodule

// File: tb/tb_adc_ctrl_axil_regs.sv
// Bench for adc_ctrl_axil_regs: directed and random AXI-Lite traffic checked against a register-map model.
module tb_adc_ctrl_axil_regs;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic        adc_start, adc_enable;
    logic [15:0] adc_clkdiv;

    int cmp_count = 0;
    int err_count = 0;
    int start_count = 0;

    // Reference model: plain register map plus status flags.
    logic [31:0] m_regs [4];
    logic        m_rdy, m_ovr;
    logic [31:0] m_data;

    always #5 aclk = ~aclk;

    adc_ctrl_axil_regs dut (
        .S_AXI_ACLK(aclk), .S_AXI_ARESETN(aresetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .adc_data_i(adc_data), .adc_data_valid_i(adc_valid),
        .adc_start_o(adc_start), .adc_enable_o(adc_enable), .adc_clkdiv_o(adc_clkdiv)
    );

    always @(negedge aclk) if (adc_start === 1'b1) start_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_count++;
        assert (obs === exp) else begin
            err_count++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        cmp_count++;
        err_count++;
        $error("FAIL %s: observed no handshake expected one within 20 cycles", tag);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_rdy = 1'b0; m_ovr = 1'b0; m_data = '0;
    endfunction

    function automatic void model_sample(input logic [15:0] d);
        if (m_rdy) m_ovr = 1'b1;
        m_rdy  = 1'b1;
        m_data = {16'h0, d};
    endfunction

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input bit inject, input logic [15:0] idata);
        int n = 0;
        int w = int'(addr[4:2]);
        logic exp_start;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        while (awready !== 1'b1 && n < 20) begin @(posedge aclk); #1; n++; end
        if (n >= 20) begin timeout_fail("aw_wait"); awvalid = 1'b0; wvalid = 1'b0; return; end
        check("wready_with_awready", {31'b0, wready}, 32'd1);
        if (inject) begin adc_valid = 1'b1; adc_data = idata; end
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0; adc_valid = 1'b0;
        exp_start = (w == 0) && strb[0] && data[0];
        if (w < 4) begin
            for (int b = 0; b < 4; b++) if (strb[b]) m_regs[w][8*b +: 8] = data[8*b +: 8];
        end else if (w == 4 && strb[0] && data[1]) begin
            m_ovr = 1'b0;
        end
        if (inject) model_sample(idata);
        check("bvalid_latency", {31'b0, bvalid}, 32'd1);
        check("bresp", {30'b0, bresp}, (w >= 6) ? 32'd2 : 32'd0);
        check("awready_one_cycle", {31'b0, awready}, 32'd0);
        check("start_pulse", {31'b0, adc_start}, {31'b0, exp_start});
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        check("bvalid_drop", {31'b0, bvalid}, 32'd0);
        check("enable_out", {31'b0, adc_enable}, {31'b0, m_regs[0][1]});
        check("clkdiv_out", {16'b0, adc_clkdiv}, {16'b0, m_regs[1][15:0]});
    endtask

    task automatic axi_read(input logic [4:0] addr, input bit inject, input logic [15:0] idata, input int hold);
        int n = 0;
        int w = int'(addr[4:2]);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        araddr = addr; arvalid = 1'b1;
        while (arready !== 1'b1 && n < 20) begin @(posedge aclk); #1; n++; end
        if (n >= 20) begin timeout_fail("ar_wait"); arvalid = 1'b0; return; end
        if (inject) begin adc_valid = 1'b1; adc_data = idata; end
        exp_resp = 2'b00;
        case (w)
            0, 1, 2, 3: exp_data = m_regs[w];
            4:          exp_data = {30'b0, m_ovr, m_rdy};
            5:          exp_data = m_data;
            default: begin exp_data = '0; exp_resp = 2'b10; end
        endcase
        if (w == 5) m_rdy = 1'b0;
        @(posedge aclk); #1;
        arvalid = 1'b0; adc_valid = 1'b0;
        if (inject) model_sample(idata);
        check("rvalid_latency", {31'b0, rvalid}, 32'd1);
        check("rdata", rdata, exp_data);
        check("rresp", {30'b0, rresp}, {30'b0, exp_resp});
        check("arready_one_cycle", {31'b0, arready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #1;
            check("rvalid_hold", {31'b0, rvalid}, 32'd1);
            check("rdata_stable", rdata, exp_data);
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        check("rvalid_drop", {31'b0, rvalid}, 32'd0);
    endtask

    task automatic pulse_sample(input logic [15:0] d);
        adc_valid = 1'b1; adc_data = d;
        @(posedge aclk); #1;
        adc_valid = 1'b0;
        model_sample(d);
    endtask

    task automatic readback_all();
        for (int a = 0; a < 6; a++) axi_read(5'(a * 4), 1'b0, 16'h0, 0);
    endtask

    initial begin
        int n;
        aresetn = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0; adc_data = '0; adc_valid = 0;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        check("rst_awready", {31'b0, awready}, 32'd0);
        check("rst_bvalid", {31'b0, bvalid}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_start", {31'b0, adc_start}, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Basic RW registers and single start pulse
        axi_write(5'h00, 32'h1, 4'hF, 1'b0, 16'h0);
        axi_write(5'h04, 32'h2, 4'hF, 1'b0, 16'h0);
        axi_write(5'h08, 32'h3, 4'hF, 1'b0, 16'h0);
        axi_write(5'h0C, 32'h4, 4'hF, 1'b0, 16'h0);
        for (int a = 0; a < 4; a++) axi_read(5'(a * 4), 1'b0, 16'h0, 1);
        check("start_count_once", start_count, 32'd1);

        // Byte strobes
        axi_write(5'h08, 32'h11223344, 4'hF, 1'b0, 16'h0);
        axi_write(5'h08, 32'hAABBCCDD, 4'b0010, 1'b0, 16'h0);
        axi_read(5'h08, 1'b0, 16'h0, 0);
        check("strobe_merge_literal", m_regs[2], 32'h1122CC44);

        // AW ahead of W; BVALID held while BREADY low blocks the next write
        awaddr = 5'h08; wdata = 32'hCAFE0001; wstrb = 4'hF; awvalid = 1'b1;
        repeat (3) begin @(posedge aclk); #1; check("aw_alone_ignored", {31'b0, awready}, 32'd0); end
        wvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 20) begin @(posedge aclk); #1; n++; end
        if (n >= 20) timeout_fail("aw_late_w_wait");
        check("wready_same_cycle", {31'b0, wready}, 32'd1);
        @(posedge aclk); #1;
        m_regs[2] = 32'hCAFE0001;
        awaddr = 5'h0C; wdata = 32'h55; wstrb = 4'hF;
        check("bvalid_after_late_w", {31'b0, bvalid}, 32'd1);
        repeat (4) begin
            @(posedge aclk); #1;
            check("bvalid_held", {31'b0, bvalid}, 32'd1);
            check("next_write_blocked", {31'b0, awready}, 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        check("bvalid_released", {31'b0, bvalid}, 32'd0);
        axi_write(5'h0C, 32'h55, 4'hF, 1'b0, 16'h0);
        axi_read(5'h08, 1'b0, 16'h0, 0);
        axi_read(5'h0C, 1'b0, 16'h0, 0);

        // Sample capture, overrun, read-clear and W1C
        pulse_sample(16'h1234);
        pulse_sample(16'h5678);
        axi_read(5'h10, 1'b0, 16'h0, 0);
        axi_read(5'h14, 1'b0, 16'h0, 0);
        axi_read(5'h10, 1'b0, 16'h0, 0);
        axi_write(5'h10, 32'h2, 4'hF, 1'b0, 16'h0);
        axi_read(5'h10, 1'b0, 16'h0, 0);

        // Unmapped addresses
        axi_read(5'h18, 1'b0, 16'h0, 0);
        axi_write(5'h1C, 32'hFFFFFFFF, 4'hF, 1'b0, 16'h0);
        readback_all();

        // Same-cycle collisions: sample during DATA read, sample vs W1C
        pulse_sample(16'h0A0A);
        axi_read(5'h14, 1'b1, 16'h0B0B, 1);
        axi_read(5'h10, 1'b0, 16'h0, 0);
        axi_write(5'h10, 32'h2, 4'h1, 1'b1, 16'h0C0C);
        axi_read(5'h10, 1'b0, 16'h0, 0);
        axi_read(5'h14, 1'b0, 16'h0, 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int op = int'($urandom_range(0, 2));
            logic [4:0] addr = 5'($urandom_range(0, 31));
            bit inj = ($urandom_range(0, 3) == 0);
            logic [15:0] sd = 16'($urandom);
            if (op == 0) axi_write(addr, $urandom, 4'($urandom_range(0, 15)), inj, sd);
            else if (op == 1) axi_read(addr, inj, sd, int'($urandom_range(0, 2)));
            else pulse_sample(sd);
        end

        // Reset while RVALID is pending
        araddr = 5'h04; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin @(posedge aclk); #1; n++; end
        if (n >= 20) timeout_fail("ar_before_reset");
        @(posedge aclk); #1;
        arvalid = 1'b0;
        check("rvalid_before_reset", {31'b0, rvalid}, 32'd1);
        #2 aresetn = 1'b0;
        #1;
        check("rvalid_async_drop", {31'b0, rvalid}, 32'd0);
        check("rdata_async_clear", rdata, 32'd0);
        model_reset();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        readback_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
